// File: rtl/ext_irq_conditioner.sv
// ext_irq_conditioner: synchronize, debounce and edge-detect external interrupt pins.
// Define EXT_IRQ_PENDING_EN for sticky pending bits cleared by irq_ack; otherwise irq_out pulses.
module ext_irq_conditioner #(
    parameter int NUM_CH          = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_CH-1:0]   irq_pin,
    input  logic [2*NUM_CH-1:0] edge_mode,
    input  logic [NUM_CH-1:0]   irq_ack,
    output logic [NUM_CH-1:0]   irq_level,
    output logic [NUM_CH-1:0]   irq_out
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] filt;
    logic [NUM_CH-1:0] filt_d;
    logic [NUM_CH-1:0] ev;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= irq_pin;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          f;
        logic          s;
        assign s = sync_q[SYNC_STAGES-1][i];
        // any cycle agreeing with the current level restarts the stability count
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt <= '0;
                f   <= 1'b0;
            end else if (s == f) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt <= '0;
                f   <= s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
        assign filt[i] = f;
        assign ev[i]   = (f & ~filt_d[i] & edge_mode[2*i]) | (~f & filt_d[i] & edge_mode[2*i+1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) filt_d <= '0;
        else          filt_d <= filt;
    end

    assign irq_level = filt;

`ifdef EXT_IRQ_PENDING_EN
    // a coinciding event keeps the bit set over an ack
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) irq_out <= '0;
        else          irq_out <= ev | (irq_out & ~irq_ack);
    end
`else
    logic unused_ack;
    assign unused_ack = ^irq_ack;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) irq_out <= '0;
        else          irq_out <= ev;
    end
`endif

endmodule

// File: tb/tb_ext_irq_conditioner.sv
// tb_ext_irq_conditioner: directed checks with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_ext_irq_conditioner;
    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] irq_pin = '0;
    logic [3:0] edge_mode = '0;
    logic [1:0] irq_ack = '0;
    logic [1:0] irq_level;
    logic [1:0] irq_out;
    int checks = 0;
    int errors = 0;
`ifdef EXT_IRQ_PENDING_EN
    localparam logic [1:0] STICK = 2'b01;
`else
    localparam logic [1:0] STICK = 2'b00;
`endif

    ext_irq_conditioner #(.NUM_CH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .irq_pin(irq_pin), .edge_mode(edge_mode),
        .irq_ack(irq_ack), .irq_level(irq_level), .irq_out(irq_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        logic [1:0] seen_out;
        logic [1:0] seen_lvl;
        int np, p1, p2, o1, t;
        logic lv6, lv13, lv14;
        step(2);
        check("reset_level", irq_level, 0);
        check("reset_out", irq_out, 0);
        reset_n = 1'b1;
        step(3);

        // single rising edge on ch0
        edge_mode = 4'b0001;
        irq_pin = 2'b01;
        step(5);
        check("t1_level_c5", irq_level, 0);
        step(1);
        check("t1_level_c6", irq_level, 2'b01);
        check("t1_out_c6", irq_out, 0);
        step(1);
        check("t1_out_c7", irq_out, 2'b01);
        step(1);
        check("t1_out_c8", irq_out, STICK);
        step(2);
        irq_ack = 2'b11;
        irq_pin = 2'b00;
        seen_out = '0;
        repeat (12) begin step(); seen_out |= irq_out; end
        check("t1_no_fall_event", seen_out, 0);
        check("t1_level_low", irq_level, 0);

        // glitches shorter than the debounce window
        seen_out = '0; seen_lvl = '0;
        irq_pin = 2'b01; step(); seen_out |= irq_out; seen_lvl |= irq_level;
        step(); seen_out |= irq_out; seen_lvl |= irq_level;
        step(); seen_out |= irq_out; seen_lvl |= irq_level;
        irq_pin = 2'b00; step(); seen_out |= irq_out; seen_lvl |= irq_level;
        irq_pin = 2'b01;
        repeat (3) begin step(); seen_out |= irq_out; seen_lvl |= irq_level; end
        irq_pin = 2'b00;
        repeat (12) begin step(); seen_out |= irq_out; seen_lvl |= irq_level; end
        check("t2_glitch_out", seen_out, 0);
        check("t2_glitch_level", seen_lvl, 0);

        // both edges on ch0, ch1 off with the same stimulus
        edge_mode = 4'b0011;
        irq_pin = 2'b11;
        np = 0; p1 = 0; p2 = 0; o1 = 0; lv6 = 0; lv13 = 0; lv14 = 1;
        for (int k = 1; k <= 24; k++) begin
            if (k == 9) irq_pin = 2'b00;
            step();
            if (irq_out[0]) begin
                np++;
                if (np == 1) p1 = k; else p2 = k;
            end
            if (irq_out[1]) o1++;
            if (k == 6) lv6 = irq_level[1];
            if (k == 13) lv13 = irq_level[1];
            if (k == 14) lv14 = irq_level[1];
        end
        check("t3_pulse_count", np, 2);
        check("t3_rise_cycle", p1, 7);
        check("t3_fall_cycle", p2, 15);
        check("t3_ch1_out", o1, 0);
        check("t3_ch1_lvl6", lv6, 1);
        check("t3_ch1_lvl13", lv13, 1);
        check("t3_ch1_lvl14", lv14, 0);

        // simultaneous events, then a mode change alone
        edge_mode = 4'b0101;
        irq_pin = 2'b11;
        step(6);
        check("t4_out_c6", irq_out, 0);
        step(1);
        check("t4_both_c7", irq_out, 2'b11);
        step(1);
        check("t4_out_c8", irq_out, 0);
        edge_mode = 4'b1111;
        seen_out = '0;
        repeat (6) begin step(); seen_out |= irq_out; end
        check("t4_mode_change", seen_out, 0);

        // ack behaviour
        edge_mode = 4'b0011;
`ifdef EXT_IRQ_PENDING_EN
        irq_ack = 2'b00;
        irq_pin = 2'b00;
        step(7);
        check("pend_set", irq_out, 2'b01);
        step(5);
        check("pend_hold", irq_out, 2'b01);
        irq_ack = 2'b01; step(); irq_ack = 2'b00;
        check("pend_clear", irq_out, 0);
        irq_pin = 2'b01;
        step(6);
        irq_ack = 2'b01; step(); irq_ack = 2'b00;
        check("pend_event_wins", irq_out, 2'b01);
        step(3);
        check("pend_hold2", irq_out, 2'b01);
        irq_ack = 2'b01; step(); irq_ack = 2'b00;
        check("pend_clear2", irq_out, 0);
`else
        irq_ack = 2'b11;
        irq_pin = 2'b00;
        step(7);
        check("ack_ign_fall", irq_out, 2'b01);
        step(1);
        check("ack_ign_end", irq_out, 0);
        irq_pin = 2'b01;
        step(7);
        check("ack_ign_rise", irq_out, 2'b01);
        step(1);
        check("ack_ign_end2", irq_out, 0);
`endif
        irq_ack = 2'b11;

        // reset mid-count discards everything
        edge_mode = 4'b0001;
        irq_pin = 2'b10;
        step(10);
        check("t5_pre_level", irq_level, 2'b10);
        irq_pin = 2'b11;
        step(3);
        reset_n = 1'b0;
        irq_pin = 2'b00;
        #1;
        check("t5_rst_level", irq_level, 0);
        check("t5_rst_out", irq_out, 0);
        step(2);
        reset_n = 1'b1;
        seen_out = '0; seen_lvl = '0;
        repeat (12) begin step(); seen_out |= irq_out; seen_lvl |= irq_level; end
        check("t5_post_out", seen_out, 0);
        check("t5_post_level", seen_lvl, 0);

        // pin held high across reset release
        reset_n = 1'b0;
        irq_pin = 2'b01;
        step(2);
        reset_n = 1'b1;
        step(6);
        check("t6_out_c6", irq_out, 0);
        check("t6_level_c6", irq_level, 2'b01);
        step(1);
        check("t6_out_c7", irq_out, 2'b01);
        step(1);
        check("t6_out_c8", irq_out, 0);

        t = checks;
        $display("Simulation finished: %0d checks, %0d errors", t, errors);
        $finish;
    end
endmodule
